// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared types and constants for the pong input path: key channel state
// encoding, pixel-clock timing constants and key index assignments.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pong_pkg;

   // Per-key debounce / repeat state
   typedef enum logic [1:0] {
      RELEASED        = 2'd0,
      CONFIRM_PRESS   = 2'd1,
      PRESSED         = 2'd2,
      CONFIRM_RELEASE = 2'd3
   } key_state_t;

   // Pixel clock for 1024x768@60
   localparam int CLK_HZ     = 65_000_000;
   localparam int CYC_PER_MS = CLK_HZ / 1000;

   // Converts a duration in milliseconds into pixel-clock cycles
   function automatic int ms_to_cycles(input int ms);
      return ms * CYC_PER_MS;
   endfunction

   localparam int CYC_20MS  = 20 * CYC_PER_MS;   // debounce window
   localparam int CYC_500MS = 500 * CYC_PER_MS;  // first auto-repeat delay
   localparam int CYC_100MS = 100 * CYC_PER_MS;  // auto-repeat period

   // Key indices as used by the game block
   localparam int KEY_DOWN = 0;
   localparam int KEY_UP   = 1;
   localparam int KEY_AUX2 = 2;
   localparam int KEY_AUX3 = 3;

endpackage

`default_nettype wire

// File: rtl/key_conditioner_if.sv
// ---------------------------------------------------------------------------
// key_conditioner_if
// Button bundle between the board pins, the key conditioner and its
// consumers (game block KEYS input, menu/score logic).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface key_conditioner_if #(
   parameter int N_KEYS = 4
) ();

   logic [N_KEYS-1:0] keys_raw_n;   // raw asynchronous buttons, 0 = pressed
   logic [N_KEYS-1:0] keys_db_n;    // debounced level, 0 = pressed
   logic [N_KEYS-1:0] press_p;      // one-cycle accepted press
   logic [N_KEYS-1:0] release_p;    // one-cycle accepted release
   logic [N_KEYS-1:0] repeat_p;     // one-cycle auto-repeat tick

   // The conditioner produces the clean levels and strobes
   modport master (
      input  keys_raw_n,
      output keys_db_n,
      output press_p,
      output release_p,
      output repeat_p
   );

   // The board side supplies raw keys and consumes the results
   modport slave (
      output keys_raw_n,
      input  keys_db_n,
      input  press_p,
      input  release_p,
      input  repeat_p
   );

endinterface

`default_nettype wire

// File: rtl/key_channel.sv
// ---------------------------------------------------------------------------
// key_channel
// One button: two-flop synchroniser, debounce FSM with confirm counter and
// auto-repeat counter. All outputs are registered.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_channel
   import pong_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = CYC_20MS,
   parameter int REPEAT_DELAY    = CYC_500MS,
   parameter int REPEAT_RATE     = CYC_100MS,
   parameter int REPEAT_EN       = 1,
   parameter int CNT_W           = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw_n,
   output logic key_db_n,
   output logic press_p,
   output logic release_p,
   output logic repeat_p
);

   localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_DELAY - 1);
   // Reloading to DELAY-RATE puts the next tick exactly RATE cycles later
   localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic             sync_q1;
   logic             sync_q2;
   key_state_t       state;
   key_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] rcnt;
   logic [CNT_W-1:0] rcnt_nxt;
   logic             db_nxt;
   logic             press_nxt;
   logic             release_nxt;
   logic             repeat_nxt;

   // Bring the asynchronous button into the clk domain; only sync_q2 is used
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
      end else begin
         sync_q1 <= key_raw_n;
         sync_q2 <= sync_q1;
      end
   end

   // Debounce / repeat decisions from the current state and synced sample
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      rcnt_nxt    = rcnt;
      db_nxt      = key_db_n;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      repeat_nxt  = 1'b0;
      case (state)
         RELEASED: begin
            if (!sync_q2) begin
               state_nxt = CONFIRM_PRESS;
               cnt_nxt   = CNT_ONE;
            end else begin
               cnt_nxt   = '0;
            end
         end
         CONFIRM_PRESS: begin
            if (sync_q2) begin
               state_nxt = RELEASED;
               cnt_nxt   = '0;
            end else if (cnt == DB_LAST) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
               rcnt_nxt  = '0;
               db_nxt    = 1'b0;
               press_nxt = 1'b1;
            end else begin
               cnt_nxt   = cnt + CNT_ONE;
            end
         end
         PRESSED: begin
            if (sync_q2) begin
               // repeat counter freezes while the release is being confirmed
               state_nxt = CONFIRM_RELEASE;
               cnt_nxt   = CNT_ONE;
            end else if (REPEAT_EN != 0) begin
               if (rcnt == RPT_LAST) begin
                  repeat_nxt = 1'b1;
                  rcnt_nxt   = RPT_RELOAD;
               end else begin
                  rcnt_nxt   = rcnt + CNT_ONE;
               end
            end
         end
         CONFIRM_RELEASE: begin
            if (!sync_q2) begin
               // bounce: resume repeat where it stopped, no new press
               state_nxt = PRESSED;
               cnt_nxt   = '0;
            end else if (cnt == DB_LAST) begin
               state_nxt   = RELEASED;
               cnt_nxt     = '0;
               db_nxt      = 1'b1;
               release_nxt = 1'b1;
            end else begin
               cnt_nxt     = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RELEASED;
         cnt       <= '0;
         rcnt      <= '0;
         key_db_n  <= 1'b1;
         press_p   <= 1'b0;
         release_p <= 1'b0;
         repeat_p  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rcnt      <= rcnt_nxt;
         key_db_n  <= db_nxt;
         press_p   <= press_nxt;
         release_p <= release_nxt;
         repeat_p  <= repeat_nxt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
// Synchronises, debounces and strobes N_KEYS independent active-low push
// buttons for the pong game block and its menu/score logic.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_conditioner
   import pong_pkg::*;
#(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = CYC_20MS,
   parameter int REPEAT_DELAY    = CYC_500MS,
   parameter int REPEAT_RATE     = CYC_100MS,
   parameter int REPEAT_EN       = 1,
   parameter int CNT_W           = 26
) (
   input  logic           clk,
   input  logic           reset,
   key_conditioner_if.master bus
);

   logic [N_KEYS-1:0] db_n;
   logic [N_KEYS-1:0] press;
   logic [N_KEYS-1:0] release_s;
   logic [N_KEYS-1:0] repeat_s;

   generate
      for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
         key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (REPEAT_EN),
            .CNT_W           (CNT_W)
         ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .key_raw_n (bus.keys_raw_n[i]),
            .key_db_n  (db_n[i]),
            .press_p   (press[i]),
            .release_p (release_s[i]),
            .repeat_p  (repeat_s[i])
         );
      end
   endgenerate

   assign bus.keys_db_n = db_n;
   assign bus.press_p   = press;
   assign bus.release_p = release_s;
   assign bus.repeat_p  = repeat_s;

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_conditioner
// Directed plus randomised stimulus against a run-length reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_key_conditioner;

   localparam int DB    = 8;
   localparam int DELAY = 20;
   localparam int RATE  = 5;

   logic clk;
   logic reset;

   key_conditioner_if #(.N_KEYS(4)) bus ();

   key_conditioner #(
      .N_KEYS          (4),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (DELAY),
      .REPEAT_RATE     (RATE),
      .REPEAT_EN       (1),
      .CNT_W           (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   // reference model state
   logic [3:0] m_db, m_press, m_rel, m_rep;
   logic [3:0] hist1, hist2;      // raw values seen one and two edges ago
   int         run  [4];          // consecutive samples disagreeing with level
   int         hold [4];          // counted held cycles since accepted press

   // random stimulus state
   logic [3:0] rr;
   int         dur [4];

   // Reference: a level flips after DB consecutive disagreeing samples;
   // while held, the Nth counted held cycle ticks at DELAY, DELAY+RATE, ...
   task automatic model_step(input logic [3:0] raw, input logic rst);
      logic [3:0] s;
      m_press = '0;
      m_rel   = '0;
      m_rep   = '0;
      if (rst) begin
         m_db  = '1;
         hist1 = '1;
         hist2 = '1;
         for (int k = 0; k < 4; k++) begin
            run[k]  = 0;
            hold[k] = 0;
         end
         return;
      end
      s     = hist2;
      hist2 = hist1;
      hist1 = raw;
      for (int k = 0; k < 4; k++) begin
         if (s[k] != m_db[k]) begin
            run[k]++;
            if (run[k] == DB) begin
               run[k]  = 0;
               m_db[k] = ~m_db[k];
               if (m_db[k] == 1'b0) begin
                  m_press[k] = 1'b1;
                  hold[k]    = 0;
               end else begin
                  m_rel[k] = 1'b1;
               end
            end
         end else begin
            if (m_db[k] == 1'b0 && run[k] == 0) begin
               hold[k]++;
               if (hold[k] >= DELAY && ((hold[k] - DELAY) % RATE) == 0)
                  m_rep[k] = 1'b1;
            end
            run[k] = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      vectors++;
      assert (bus.keys_db_n === m_db) else begin
         miscompares++;
         $error("FAIL %s keys_db_n cyc=%0d got=%b exp=%b", tag, cyc, bus.keys_db_n, m_db);
      end
      vectors++;
      assert (bus.press_p === m_press) else begin
         miscompares++;
         $error("FAIL %s press_p cyc=%0d got=%b exp=%b", tag, cyc, bus.press_p, m_press);
      end
      vectors++;
      assert (bus.release_p === m_rel) else begin
         miscompares++;
         $error("FAIL %s release_p cyc=%0d got=%b exp=%b", tag, cyc, bus.release_p, m_rel);
      end
      vectors++;
      assert (bus.repeat_p === m_rep) else begin
         miscompares++;
         $error("FAIL %s repeat_p cyc=%0d got=%b exp=%b", tag, cyc, bus.repeat_p, m_rep);
      end
      vectors++;
      assert (((bus.press_p & bus.release_p) | (bus.press_p & bus.repeat_p) |
               (bus.release_p & bus.repeat_p)) === 4'b0000) else begin
         miscompares++;
         $error("FAIL %s exclusive cyc=%0d got p=%b r=%b t=%b exp=none overlapping",
                tag, cyc, bus.press_p, bus.release_p, bus.repeat_p);
      end
   endtask

   task automatic expect_v(input string tag, input logic [3:0] got, input logic [3:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
      end
   endtask

   // One clock: drive, let the edge happen, advance model, sample after edge
   task automatic tick(input logic [3:0] raw, input logic rst, input string tag);
      bus.keys_raw_n = raw;
      reset          = rst;
      @(posedge clk);
      model_step(raw, rst);
      #1;
      check_all(tag);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(4'hF, 1'b0, "idle");
   endtask

   initial begin
      bus.keys_raw_n = 4'hF;
      reset          = 1'b1;
      m_db = '1; m_press = '0; m_rel = '0; m_rep = '0;
      hist1 = '1; hist2 = '1;
      for (int k = 0; k < 4; k++) begin
         run[k] = 0; hold[k] = 0;
      end

      // 1: reset held with all keys low, then one cycle after
      for (int i = 0; i < 3; i++) begin
         tick(4'h0, 1'b1, "reset");
         expect_v("reset_db", bus.keys_db_n, 4'hF);
         expect_v("reset_pulses", bus.press_p | bus.release_p | bus.repeat_p, 4'h0);
      end
      tick(4'h0, 1'b0, "post_reset");
      expect_v("post_reset_pulses", bus.press_p | bus.release_p | bus.repeat_p, 4'h0);
      idle(12);

      // 2: clean press of key 0, edge numbering from first capture
      for (int k = 0; k <= 40; k++) begin
         tick(4'b1110, 1'b0, "press0");
         expect_v("press0_p", {3'b000, bus.press_p[0]}, {3'b000, (k == 9)});
         expect_v("press0_db", {3'b000, bus.keys_db_n[0]}, {3'b000, (k < 9)});
         expect_v("press0_rep", {3'b000, bus.repeat_p[0]},
                  {3'b000, (k >= 29 && ((k - 29) % 5) == 0)});
      end

      // 4: bouncy release of key 0
      for (int j = 0; j < 5; j++) begin
         tick((j < 3) ? 4'b1111 : 4'b1110, 1'b0, "bounce");
         expect_v("bounce_rel", {3'b000, bus.release_p[0]}, 4'b0000);
      end
      for (int j = 0; j < 14; j++) begin
         tick(4'b1111, 1'b0, "release0");
         expect_v("release0_p", {3'b000, bus.release_p[0]}, {3'b000, (j == 9)});
      end
      idle(4);

      // 3: glitch on key 1 shorter than the debounce window
      for (int j = 0; j < 17; j++) begin
         tick((j < 5) ? 4'b1101 : 4'b1111, 1'b0, "glitch1");
         expect_v("glitch1_db", {3'b000, bus.keys_db_n[1]}, 4'b0001);
         expect_v("glitch1_pulse", {3'b000, bus.press_p[1] | bus.release_p[1] | bus.repeat_p[1]}, 4'b0000);
      end

      // 5: keys 0 and 3 together
      for (int k = 0; k <= 40; k++) begin
         tick(4'b0110, 1'b0, "simul");
         expect_v("simul_press", bus.press_p, (k == 9) ? 4'b1001 : 4'b0000);
         expect_v("simul_rep_align", {3'b000, bus.repeat_p[0]}, {3'b000, bus.repeat_p[3]});
      end
      idle(14);

      // 6: reset in the middle of confirming key 2
      for (int k = 0; k <= 5; k++) begin
         tick(4'b1011, (k == 5), "midreset");
         expect_v("midreset_p", {3'b000, bus.press_p[2]}, 4'b0000);
      end
      for (int j = 0; j <= 12; j++) begin
         tick(4'b1011, 1'b0, "after_reset");
         expect_v("after_reset_p", {3'b000, bus.press_p[2]}, {3'b000, (j == 9)});
      end
      idle(14);

      // randomised independent key activity with rare resets
      rr = 4'hF;
      for (int k = 0; k < 4; k++) dur[k] = $urandom_range(1, 35);
      for (int c = 0; c < 800; c++) begin
         for (int k = 0; k < 4; k++) begin
            if (dur[k] == 0) begin
               rr[k]  = ~rr[k];
               dur[k] = $urandom_range(1, 35);
            end else begin
               dur[k]--;
            end
         end
         tick(rr, ($urandom_range(0, 249) == 0), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
